// File: rtl/alu32_bit.sv
// -----------------------------------------------------------------------------
// alu32_bit
// Execute-stage 32-bit integer ALU for a five-stage MIPS pipeline, including
// the architectural HI/LO register pair.
//
// ALUResult and Zero are purely combinational from A, B, ALUControl, Shamt and
// the current HI/LO contents. HI/LO are the only state in the block. They
// update on the rising Clk edge when HiLoWrite is set and the operation is
// MULT/MULTU/MADD/MSUB/MTHI/MTLO.
//
// Configuration macro:
//   ALU_MADD_EN  - when defined, codes 18/19 perform MADD/MSUB, accumulating
//                  into {HI,LO}. When undefined, the accumulate datapath is not
//                  built and codes 18/19 behave as reserved: result 0 and no
//                  HI/LO effect.
//
// Ports:
//   Clk        in   1  rising-edge clock
//   Reset      in   1  synchronous active-low reset, clears HI/LO
//   ALUControl in   5  operation code
//   A          in  32  operand A (rs path)
//   B          in  32  operand B (rt / immediate path)
//   HiLoWrite  in   1  enables the HI/LO update for HI/LO-writing ops
//   Shamt      in   5  static shift amount (instruction bits [10:6])
//   ALUResult  out 32  combinational result
//   Zero       out  1  set when ALUResult is zero
//   Debug_HI   out 32  current HI register
//   Debug_LO   out 32  current LO register
// -----------------------------------------------------------------------------
module alu32_bit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoWrite,
    input  logic [4:0]  Shamt,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic [31:0] Debug_HI,
    output logic [31:0] Debug_LO
);

    // Operation codes
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_SLLV  = 5'd11;
    localparam logic [4:0] OP_SRLV  = 5'd12;
    localparam logic [4:0] OP_SRAV  = 5'd13;
    localparam logic [4:0] OP_ROTR  = 5'd14;
    localparam logic [4:0] OP_ROTRV = 5'd15;
    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd17;
    localparam logic [4:0] OP_MADD  = 5'd18;
    localparam logic [4:0] OP_MSUB  = 5'd19;
    localparam logic [4:0] OP_MTHI  = 5'd20;
    localparam logic [4:0] OP_MTLO  = 5'd21;
    localparam logic [4:0] OP_MFHI  = 5'd22;
    localparam logic [4:0] OP_MFLO  = 5'd23;
    localparam logic [4:0] OP_LUI   = 5'd24;
    localparam logic [4:0] OP_SEB   = 5'd25;
    localparam logic [4:0] OP_SEH   = 5'd26;
    localparam logic [4:0] OP_MUL   = 5'd27;
    localparam logic [4:0] OP_PASSA = 5'd28;
    localparam logic [4:0] OP_PASSB = 5'd29;
    localparam logic [4:0] OP_RSV30 = 5'd30;
    localparam logic [4:0] OP_RSV31 = 5'd31;

    // Rotate right: shifting the doubled word right leaves the rotated value
    // in the low half, which also handles a zero amount without special cases.
    function automatic logic [31:0] rotr32(input logic [31:0] val, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {val, val} >> amt;
        return dbl[31:0];
    endfunction

    // Sign-extend the low byte.
    function automatic logic [31:0] sext8(input logic [7:0] val);
        return {{24{val[7]}}, val};
    endfunction

    // Sign-extend the low halfword.
    function automatic logic [31:0] sext16(input logic [15:0] val);
        return {{16{val[15]}}, val};
    endfunction

    // Architectural HI/LO. They power up at zero so that software sees a
    // defined value even before the first reset.
    logic [31:0] hi_q = 32'd0;
    logic [31:0] lo_q = 32'd0;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    logic [31:0] result_s;
    logic [4:0]  var_sh_s;
    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;

    // The variable shift amount comes from the low five bits of operand A.
    assign var_sh_s = A[4:0];

    // Full 64-bit products. The operands are widened first so that the
    // multiply is evaluated at 64 bits; the signed form sign-extends.
    assign prod_signed_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_unsigned_s = {32'd0, A} * {32'd0, B};

    // Combinational result mux for every operation code.
    always_comb begin
        result_s = 32'd0;
        case (ALUControl)
            OP_ADD:   result_s = A + B;
            OP_SUB:   result_s = A - B;
            OP_AND:   result_s = A & B;
            OP_OR:    result_s = A | B;
            OP_XOR:   result_s = A ^ B;
            OP_NOR:   result_s = ~(A | B);
            OP_SLT:   result_s = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            OP_SLTU:  result_s = (A < B) ? 32'd1 : 32'd0;
            OP_SLL:   result_s = B << Shamt;
            OP_SRL:   result_s = B >> Shamt;
            OP_SRA:   result_s = $signed(B) >>> Shamt;
            OP_SLLV:  result_s = B << var_sh_s;
            OP_SRLV:  result_s = B >> var_sh_s;
            OP_SRAV:  result_s = $signed(B) >>> var_sh_s;
            OP_ROTR:  result_s = rotr32(B, Shamt);
            OP_ROTRV: result_s = rotr32(B, var_sh_s);
            // HI/LO writers and the reserved codes produce no result.
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB,
            OP_MTHI, OP_MTLO, OP_RSV30, OP_RSV31:
                      result_s = 32'd0;
            // Reads see the register value before any write on this edge.
            OP_MFHI:  result_s = hi_q;
            OP_MFLO:  result_s = lo_q;
            OP_LUI:   result_s = {B[15:0], 16'd0};
            OP_SEB:   result_s = sext8(B[7:0]);
            OP_SEH:   result_s = sext16(B[15:0]);
            OP_MUL:   result_s = prod_signed_s[31:0];
            OP_PASSA: result_s = A;
            OP_PASSB: result_s = B;
            default:  result_s = 32'd0;
        endcase
    end

    // Next-state logic for HI/LO; anything other than an enabled writer holds.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (HiLoWrite) begin
            case (ALUControl)
                OP_MULT:  {hi_d, lo_d} = prod_signed_s;
                OP_MULTU: {hi_d, lo_d} = prod_unsigned_s;
`ifdef ALU_MADD_EN
                // Accumulate wraps modulo 2^64.
                OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_signed_s;
                OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_signed_s;
`endif
                OP_MTHI:  hi_d = A;
                OP_MTLO:  lo_d = A;
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // HI/LO registers; reset takes priority over a simultaneous write.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign ALUResult = result_s;
    assign Zero      = (result_s == 32'd0);
    assign Debug_HI  = hi_q;
    assign Debug_LO  = lo_q;

endmodule

// File: tb/tb_alu32_bit.sv
// -----------------------------------------------------------------------------
// tb_alu32_bit
// Directed testbench for alu32_bit. Every expected value below is
// hand-computed. Combinational results are sampled 1 time unit after the
// inputs change; HI/LO are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu32_bit;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoWrite;
    logic [4:0]  Shamt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] Debug_HI;
    logic [31:0] Debug_LO;

    int passed;
    int total;

    alu32_bit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .HiLoWrite  (HiLoWrite),
        .Shamt      (Shamt),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Debug_HI   (Debug_HI),
        .Debug_LO   (Debug_LO)
    );

    // Free-running clock, period 10.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Apply a combinational operation and let it settle.
    task automatic op(input logic [4:0] code, input logic [31:0] a_v, input logic [31:0] b_v,
                      input logic [4:0] sh, input logic hlw);
        ALUControl = code;
        A          = a_v;
        B          = b_v;
        Shamt      = sh;
        HiLoWrite  = hlw;
        #1;
    endtask

    // Advance through one rising edge and sample shortly after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        passed = 0;
        total  = 0;
        Reset  = 1'b1;
        op(5'd0, 32'd0, 32'd0, 5'd0, 1'b0);

        // Power-up value before any reset.
        chk("init_hi", Debug_HI, 32'h0000_0000);
        chk("init_lo", Debug_LO, 32'h0000_0000);

        // Reset, then MFHI reads 0 and Zero is set.
        Reset = 1'b0;
        tick();
        chk("rst_hi", Debug_HI, 32'h0000_0000);
        chk("rst_lo", Debug_LO, 32'h0000_0000);
        op(5'd22, 32'd0, 32'd0, 5'd0, 1'b0);
        chk("rst_mfhi", ALUResult, 32'h0000_0000);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        Reset = 1'b1;
        tick();

        // Arithmetic / logic / compare.
        op(5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
        chk("add_ovf", ALUResult, 32'h8000_0000);
        chk("add_zero", {31'd0, Zero}, 32'd0);
        op(5'd1, 32'd5, 32'd5, 5'd0, 1'b0);
        chk("sub_eq", ALUResult, 32'h0000_0000);
        chk("sub_zero", {31'd0, Zero}, 32'd1);
        op(5'd5, 32'd0, 32'd0, 5'd0, 1'b0);
        chk("nor", ALUResult, 32'hFFFF_FFFF);
        op(5'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b0);
        chk("xor", ALUResult, 32'hFF00_EDCB);
        op(5'd6, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
        chk("slt", ALUResult, 32'h0000_0001);
        op(5'd7, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
        chk("sltu", ALUResult, 32'h0000_0000);

        // Shifts and rotates.
        op(5'd10, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
        chk("sra", ALUResult, 32'hF800_0000);
        op(5'd9, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
        chk("srl", ALUResult, 32'h0800_0000);
        op(5'd11, 32'h0000_0024, 32'h0000_0001, 5'd0, 1'b0);
        chk("sllv", ALUResult, 32'h0000_0010);
        op(5'd13, 32'h0000_0008, 32'h8000_0000, 5'd0, 1'b0);
        chk("srav", ALUResult, 32'hFF80_0000);
        op(5'd14, 32'd0, 32'h0000_0001, 5'd1, 1'b0);
        chk("rotr", ALUResult, 32'h8000_0000);
        op(5'd15, 32'h0000_0004, 32'h0000_00F1, 5'd0, 1'b0);
        chk("rotrv", ALUResult, 32'h1000_000F);

        // Immediate helpers, MUL, pass-through, reserved.
        op(5'd24, 32'd0, 32'h0000_1234, 5'd0, 1'b0);
        chk("lui", ALUResult, 32'h1234_0000);
        op(5'd25, 32'd0, 32'h0000_0080, 5'd0, 1'b0);
        chk("seb", ALUResult, 32'hFFFF_FF80);
        op(5'd26, 32'd0, 32'h0001_7FFF, 5'd0, 1'b0);
        chk("seh", ALUResult, 32'h0000_7FFF);
        op(5'd27, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 1'b0);
        chk("mul", ALUResult, 32'hFFFF_FFFA);
        op(5'd28, 32'hCAFE_0001, 32'h0000_0002, 5'd0, 1'b0);
        chk("passa", ALUResult, 32'hCAFE_0001);
        op(5'd30, 32'hCAFE_0001, 32'h0000_0002, 5'd0, 1'b1);
        chk("rsv30", ALUResult, 32'h0000_0000);
        tick();
        chk("rsv30_hi", Debug_HI, 32'h0000_0000);

        // MULT: result 0 now, HI/LO after the edge, MFLO next cycle.
        op(5'd16, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 1'b1);
        chk("mult_res", ALUResult, 32'h0000_0000);
        tick();
        chk("mult_hi", Debug_HI, 32'hFFFF_FFFF);
        chk("mult_lo", Debug_LO, 32'hFFFF_FFFA);
        op(5'd23, 32'd0, 32'd0, 5'd0, 1'b0);
        chk("mflo", ALUResult, 32'hFFFF_FFFA);

        // MULTU with the same operands.
        op(5'd17, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 1'b1);
        tick();
        chk("multu_hi", Debug_HI, 32'h0000_0002);
        chk("multu_lo", Debug_LO, 32'hFFFF_FFFA);

        // Writer without enable, and enable with a non-writer: no change.
        op(5'd17, 32'd5, 32'd5, 5'd0, 1'b0);
        tick();
        chk("nowe_hi", Debug_HI, 32'h0000_0002);
        chk("nowe_lo", Debug_LO, 32'hFFFF_FFFA);
        op(5'd0, 32'd7, 32'd9, 5'd0, 1'b1);
        tick();
        chk("nonwr_hi", Debug_HI, 32'h0000_0002);

        // Reset wins over a simultaneous MTHI; next edge the write lands.
        Reset = 1'b0;
        op(5'd20, 32'h0000_1234, 32'd0, 5'd0, 1'b1);
        tick();
        chk("rstpri_hi", Debug_HI, 32'h0000_0000);
        chk("rstpri_lo", Debug_LO, 32'h0000_0000);
        Reset = 1'b1;
        tick();
        chk("mthi_hi", Debug_HI, 32'h0000_1234);
        op(5'd22, 32'd0, 32'd0, 5'd0, 1'b0);
        chk("mfhi", ALUResult, 32'h0000_1234);

        // Set up HI=0, LO=0xFFFFFFFF for the accumulate checks.
        op(5'd21, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b1);
        tick();
        op(5'd20, 32'h0000_0000, 32'd0, 5'd0, 1'b1);
        tick();
        chk("setup_lo", Debug_LO, 32'hFFFF_FFFF);

        op(5'd18, 32'd1, 32'd1, 5'd0, 1'b1);
        chk("madd_res", ALUResult, 32'h0000_0000);
        tick();
`ifdef ALU_MADD_EN
        chk("madd_hi", Debug_HI, 32'h0000_0001);
        chk("madd_lo", Debug_LO, 32'h0000_0000);
`else
        chk("madd_hi", Debug_HI, 32'h0000_0000);
        chk("madd_lo", Debug_LO, 32'hFFFF_FFFF);
`endif
        op(5'd19, 32'd1, 32'd1, 5'd0, 1'b1);
        chk("msub_res", ALUResult, 32'h0000_0000);
        tick();
        chk("msub_hi", Debug_HI, 32'h0000_0000);
        chk("msub_lo", Debug_LO, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu32_bit.md
# alu32_bit

Execute-stage 32-bit integer ALU for the five-stage MIPS pipeline, with architectural HI/LO registers. Result and zero flag are combinational from operands `A` and `B`, the 5-bit operation code and the shift amount. HI/LO are the only state; they update on the clock edge under `HiLoWrite`. The block sits after the forwarding muxes; its result feeds the EX/MEM register.

## Interface
- No parameters.
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: synchronous, active-low reset; clears HI/LO.
- `ALUControl` input 5: operation code (see Operation).
- `A` input 32: operand A (rs path).
- `B` input 32: operand B (rt or immediate path).
- `HiLoWrite` input 1: enables the HI/LO update for HI/LO-writing ops.
- `Shamt` input 5: shift amount (instruction bits [10:6]).
- `ALUResult` output 32: combinational result.
- `Zero` output 1: 1 when `ALUResult` == 0.
- `Debug_HI` output 32: current HI register.
- `Debug_LO` output 32: current LO register.

## Operation
- Codes 0–4:
  - 0 ADD: A+B, wraps, no overflow trap.
  - 1 SUB: A−B, wraps.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
- Codes 5–7:
  - 5 NOR.
  - 6 SLT: signed compare, result 1/0.
  - 7 SLTU: unsigned compare, result 1/0.
- Codes 8–10:
  - 8 SLL: B<<Shamt.
  - 9 SRL: B>>Shamt, logical.
  - 10 SRA: B>>>Shamt, arithmetic.
- Codes 11–13:
  - 11 SLLV: B<<A[4:0].
  - 12 SRLV: B>>A[4:0], logical.
  - 13 SRAV: B>>>A[4:0], arithmetic.
- Codes 14–15:
  - 14 ROTR: B rotated right by Shamt.
  - 15 ROTRV: B rotated right by A[4:0].
- Codes 16–19 (HI/LO-writing):
  - 16 MULT: {HI,LO} ← signed A×B.
  - 17 MULTU: {HI,LO} ← unsigned A×B.
  - 18 MADD: {HI,LO} ← {HI,LO} + signed A×B.
  - 19 MSUB: {HI,LO} ← {HI,LO} − signed A×B.
  - ALUResult is 0 for all four.
- Codes 20–23:
  - 20 MTHI: HI ← A; ALUResult 0.
  - 21 MTLO: LO ← A; ALUResult 0.
  - 22 MFHI: ALUResult = HI.
  - 23 MFLO: ALUResult = LO.
- Codes 24–26:
  - 24 LUI: B<<16.
  - 25 SEB: sign-extend B[7:0].
  - 26 SEH: sign-extend B[15:0].
- Codes 27–31:
  - 27 MUL: low 32 bits of signed A×B; HI/LO untouched.
  - 28 PASSA: A.
  - 29 PASSB: B.
  - 30, 31 reserved: ALUResult 0, no HI/LO effect.
- HI/LO write rules:
  - HI/LO change only when `HiLoWrite`=1 and the code is one of 16–21.
  - A HI/LO-writing code with `HiLoWrite`=0 leaves HI/LO unchanged.
  - `HiLoWrite`=1 with any other code leaves HI/LO unchanged.
- MADD/MSUB arithmetic is full 64-bit, wrapping modulo 2^64.

## Timing
- `ALUResult` and `Zero` are purely combinational, zero-cycle latency.
- HI/LO update at the rising `Clk` edge when write-enabled.
- MFHI/MFLO read the pre-edge register value. MFHI in the cycle after a MULT returns the new HI.
- Reset:
  - `Reset`=0 at a rising edge sets HI=LO=0.
  - Reset has priority over a simultaneous HI/LO write.
  - Reset does not affect the combinational outputs.
- After reset, `Debug_HI`=`Debug_LO`=0. MFHI then yields 0 and `Zero`=1.
- Before the first reset, HI/LO are 0 via register initialisation.

## Configuration
- `ALU_MADD_EN`
  - Defined: codes 18/19 perform MADD/MSUB as above.
  - Undefined: the accumulate logic is not compiled. Codes 18/19 act as reserved: ALUResult 0, HI/LO unchanged even with `HiLoWrite`=1.

## Test plan
- ADD 0x7FFFFFFF+1 → 0x80000000, Zero=0. SUB 5−5 → 0, Zero=1.
- SLT A=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0. SRA B=0x80000000, Shamt=4 → 0xF8000000. ROTR B=0x00000001, Shamt=1 → 0x80000000.
- MULT A=0xFFFFFFFE (−2), B=3, `HiLoWrite`=1, one edge → HI=0xFFFFFFFF, LO=0xFFFFFFFA. Next cycle MFLO → 0xFFFFFFFA.
- MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA. Same op with `HiLoWrite`=0 → HI/LO unchanged.
- MTHI A=0x1234 with `Reset`=0 on the same edge → HI=0. Next edge, `Reset`=1 → HI=0x1234.
- With `ALU_MADD_EN`, HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 → HI=1, LO=0. Without `ALU_MADD_EN` → HI/LO unchanged, ALUResult 0.
